// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared state encoding and defaults for the data-memory responder
package dmem_responder_pkg;

    localparam int DMEM_WAIT_STATES_DEFAULT = 2;
    localparam int DMEM_CNT_W               = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - MEM-stage request/response bundle between pipeline and responder
interface dmem_responder_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              stall;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, stall
    );
endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word array, synchronous write and read, contents survive reset
module dmem_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Read register only moves on a load, so a store leaves the last load result intact.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory responder: request latch, stall counter, FSM
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int WAIT_STATES = DMEM_WAIT_STATES_DEFAULT,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_responder_if.slave bus
);
    localparam logic [DMEM_CNT_W-1:0] WS_CNT  = DMEM_CNT_W'(WAIT_STATES);
    localparam logic [DMEM_CNT_W-1:0] CNT_ONE = DMEM_CNT_W'(1);
    localparam bit                    NO_WAIT = (WAIT_STATES == 0);

    dmem_state_t           state_q, state_d;
    logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  rsp_valid_q;
    logic                  rd_seen_q;
    logic                  handshake;
    logic                  exec;
    logic                  acc_we;
    logic [ADDR_W-1:0]     acc_addr;
    logic [DATA_W-1:0]     acc_wdata;
    logic [DATA_W-1:0]     arr_rdata;

    assign handshake = bus.req_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exec    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    cnt_d = WS_CNT;
                    if (NO_WAIT) begin
                        exec    = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    exec    = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (handshake) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    // With no wait states the access fires on the handshake edge itself, before the latch holds anything.
    assign acc_we    = NO_WAIT ? bus.req_we    : we_q;
    assign acc_addr  = NO_WAIT ? bus.req_addr  : addr_q;
    assign acc_wdata = NO_WAIT ? bus.req_wdata : wdata_q;

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .en    (exec),
        .we    (acc_we),
        .addr  (acc_addr),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    // The array read register has no reset, so rsp_rdata reads zero until a load lands after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rd_seen_q   <= 1'b0;
        end else begin
            rsp_valid_q <= exec;
            if (exec && !acc_we) begin
                rd_seen_q <= 1'b1;
            end
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.stall     = handshake || (state_q == ST_WAIT);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rd_seen_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder at WAIT_STATES 2 and 0
module tb_dmem_responder;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();
    dmem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();

    dmem_responder #(.WAIT_STATES(2), .ADDR_W(AW), .DATA_W(DW)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    dmem_responder #(.WAIT_STATES(0), .ADDR_W(AW), .DATA_W(DW)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_rdata [3];
    logic [DW-1:0] mem0 [int];
    logic [DW-1:0] mem2 [int];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int ws, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (ws == 0) begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = a; bus0.req_wdata = d;
        end else begin
            bus2.req_valid = v; bus2.req_we = we; bus2.req_addr = a; bus2.req_wdata = d;
        end
    endtask

    function automatic logic get_ready(input int ws);
        return (ws == 0) ? bus0.req_ready : bus2.req_ready;
    endfunction
    function automatic logic get_stall(input int ws);
        return (ws == 0) ? bus0.stall : bus2.stall;
    endfunction
    function automatic logic get_rv(input int ws);
        return (ws == 0) ? bus0.rsp_valid : bus2.rsp_valid;
    endfunction
    function automatic logic [DW-1:0] get_rdata(input int ws);
        return (ws == 0) ? bus0.rsp_rdata : bus2.rsp_rdata;
    endfunction

    task automatic pop_check(input string tag, input logic [DW-1:0] obs);
        logic [DW-1:0] e;
        check({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // Single access from IDLE; returns at posedge+1 with the DUT back in IDLE.
    task automatic access(input int ws, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit scramble);
        int stall_cnt = 0;
        int rsp_cyc   = -1;
        logic [DW-1:0] e;
        if (we) begin
            e = last_rdata[ws];
            if (ws == 0) mem0[int'(a)] = d; else mem2[int'(a)] = d;
        end else begin
            e = (ws == 0) ? mem0[int'(a)] : mem2[int'(a)];
            last_rdata[ws] = e;
        end
        exp_q.push_back(e);
        drive(ws, 1'b1, we, a, d);
        for (int cyc = 0; cyc <= ws + 4 && rsp_cyc < 0; cyc++) begin
            @(negedge clk);
            if (get_stall(ws)) stall_cnt++;
            if (cyc == 0) check("ready_idle", 64'(get_ready(ws)), 64'd1);
            else          check("ready_busy", 64'(get_ready(ws)), 64'd0);
            if (get_rv(ws)) begin
                rsp_cyc = cyc;
                pop_check(we ? "store_rdata_held" : "load_rdata", get_rdata(ws));
                check("stall_in_resp", 64'(get_stall(ws)), 64'd0);
            end
            @(posedge clk);
            #1;
            if (scramble) drive(ws, 1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
            else          drive(ws, 1'b0, we, a, d);
        end
        check("latency", 64'(rsp_cyc), 64'(ws + 1));
        check("stall_cycles", 64'(stall_cnt), 64'(ws + 1));
    endtask

    task automatic back_to_back();
        int hs[$];
        int rs[$];
        int hs1;
        exp_q.push_back(mem2[5]);
        exp_q.push_back(mem2[10]);
        last_rdata[2] = mem2[10];
        drive(2, 1'b1, 1'b0, 10'h005, '0);
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (bus2.req_ready && bus2.req_valid) hs.push_back(cyc);
            if ((cyc >= 1 && cyc <= 3) || (cyc >= 5 && cyc <= 7))
                check("b2b_ready_busy", 64'(bus2.req_ready), 64'd0);
            if (bus2.rsp_valid) begin
                rs.push_back(cyc);
                pop_check("b2b_rdata", bus2.rsp_rdata);
            end
            @(posedge clk);
            #1;
            if (cyc == 0) drive(2, 1'b1, 1'b0, 10'h00A, '0);
            if (hs.size() >= 2) drive(2, 1'b0, 1'b0, '0, '0);
        end
        hs1 = (hs.size() > 1) ? hs[1] - hs[0] : -1;
        check("b2b_handshakes", 64'(hs.size()), 64'd2);
        check("b2b_hs_spacing", 64'(hs1), 64'd4);
        check("b2b_rsp_count", 64'(rs.size()), 64'd2);
        check("b2b_rsp_last", 64'((rs.size() > 1) ? rs[1] : -1), 64'd7);
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(2, 1'b0, 1'b0, '0, '0);
        last_rdata[0] = '0; last_rdata[1] = '0; last_rdata[2] = '0;
        #2;
        check("rst_ready", 64'(bus2.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus2.rsp_valid), 64'd0);
        check("rst_rdata", 64'(bus2.rsp_rdata), 64'd0);
        check("rst_stall_low", 64'(bus2.stall), 64'd0);
        bus2.req_valid = 1'b1;
        #1;
        check("rst_stall_follows_valid", 64'(bus2.stall), 64'd1);
        bus2.req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        access(2, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0);
        access(2, 1'b0, 10'h005, '0, 1'b0);
        access(2, 1'b1, 10'h00A, 32'hCAFEF00D, 1'b1);
        access(2, 1'b0, 10'h00A, '0, 1'b1);
        access(2, 1'b1, 10'h3FF, 32'h0F0F0F0F, 1'b0);
        access(2, 1'b0, 10'h3FF, '0, 1'b0);

        access(0, 1'b1, 10'h3FF, 32'h12345678, 1'b0);
        access(0, 1'b0, 10'h3FF, '0, 1'b0);
        access(0, 1'b1, 10'h000, 32'h0BADF00D, 1'b0);
        access(0, 1'b0, 10'h000, '0, 1'b0);

        back_to_back();

        access(2, 1'b1, 10'h010, 32'h00000001, 1'b0);
        drive(2, 1'b1, 1'b1, 10'h010, 32'hA5A5A5A5);
        @(posedge clk);
        #1;
        drive(2, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        check("abort_stall_in_wait", 64'(bus2.stall), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 64'(bus2.rsp_valid), 64'd0);
        check("abort_rdata", 64'(bus2.rsp_rdata), 64'd0);
        check("abort_ready", 64'(bus2.req_ready), 64'd1);
        check("abort_stall", 64'(bus2.stall), 64'd0);
        check("abort_rdata_ws0", 64'(bus0.rsp_rdata), 64'd0);
        @(posedge clk);
        #1;
        check("abort_held_rsp_valid", 64'(bus2.rsp_valid), 64'd0);
        rst_n = 1'b1;
        last_rdata[0] = '0;
        last_rdata[2] = '0;
        @(posedge clk);
        #1;
        access(2, 1'b0, 10'h010, '0, 1'b0);
        access(2, 1'b0, 10'h005, '0, 1'b0);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
